instr_serializer: RTL
=====================

INSTR_SERIALIZER -- requirements
Module: instr_serializer

Interface
REQ-001 SHALL have parameter RNONE, default 4'hF: register code placed in every unused rA/rB nibble.
REQ-002 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: instruction fields valid.
REQ-005 SHALL have port in_ready, output, 1: block accepts fields this cycle.
REQ-006 SHALL have ports icode, ifun, rA, rB, input, 4 each: instruction fields.
REQ-007 SHALL have port Dest, input, 32: jump/call target.
REQ-008 SHALL have port D_V, input, 32: displacement/immediate.
REQ-009 SHALL have port out_byte, output, 8: current instruction byte.
REQ-010 SHALL have port out_valid, output, 1: out_byte valid.
REQ-011 SHALL have port out_ready, input, 1: consumer takes out_byte.
REQ-012 SHALL have port out_last, output, 1: out_byte is the final byte of the instruction.
REQ-013 SHALL have port out_idx, output, 3: byte index 0..5 of out_byte.
REQ-014 SHALL have port err, output, 1: one-cycle pulse on rejected illegal icode.

Function
REQ-015 SHALL capture all fields into holding registers on in_valid && in_ready; later input changes SHALL have no effect until the next accept.
REQ-016 SHALL use states IDLE and SEND; IDLE->SEND on accept; SEND->IDLE on out_valid && out_ready && out_last, unless a new accept occurs in the same cycle.
REQ-017 in_ready SHALL be 1 in IDLE, and in SEND only during the cycle where the last byte is taken; a same-cycle accept SHALL go straight to SEND with out_idx=0 (back-to-back, no bubble).
REQ-018 out_valid SHALL be 1 exactly in SEND, starting the cycle after accept (latency 1).
REQ-019 Byte layout: B0={icode,ifun}, B1={rA,rB}.
REQ-020 For icode 7 and 8, B1..B4 SHALL be Dest[7:0]..Dest[31:24]; B1 carries no register nibbles.
REQ-021 For icode 3, 4 and 5, B2..B5 SHALL be D_V[7:0]..D_V[31:24].
REQ-022 Instruction length SHALL be: 1 byte for icode 0, 1 and 9; 2 bytes for icode 2, 6, A and B; 5 bytes for icode 7 and 8; 6 bytes for icode 3, 4 and 5.
REQ-023 Register forcing: icode 3 SHALL force rA=RNONE; icode A and B SHALL force rB=RNONE; all other rA/rB values pass unchanged.
REQ-024 out_idx SHALL increment by 1 on each out_valid && out_ready; it SHALL hold when out_ready=0; out_byte/out_last SHALL stay stable while stalled.
REQ-025 out_last SHALL be 1 exactly when out_idx == length-1.
REQ-026 out_byte SHALL be 8'h00 whenever out_valid=0.

Reset
REQ-027 On reset assertion, regardless of clk, the block SHALL go to IDLE, with out_valid=0, out_last=0, out_idx=0, out_byte=0, err=0 and holding registers=0.
REQ-028 Reset mid-instruction SHALL drop the remaining bytes; no partial resume after release.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-030 With macro ISER_ILLEGAL_CHK_EN defined, icode C-F SHALL be accepted but not emitted: state stays IDLE and err pulses high for one cycle after accept.
REQ-031 Without ISER_ILLEGAL_CHK_EN, icode C-F SHALL be emitted as a 1-byte instruction and err SHALL be tied 0.

Verification
REQ-032 Fields icode=3, ifun=0, rA=2, rB=3, D_V=32'h12345678, out_ready=1 -> bytes 30,F3,78,56,34,12 on idx 0..5; out_last only on the byte 12.
REQ-033 Fields icode=7, ifun=3, Dest=32'hDEADBEEF -> bytes 73,EF,BE,AD,DE; out_last on DE; in_ready=1 only on the last-byte cycle.
REQ-034 Back-to-back pushq (A0, rA=4) then ret (90) with in_valid held -> stream A0,4F,90 on consecutive cycles, no bubble.
REQ-035 rmmovq with D_V=32'h00000010 and out_ready toggling 1,0,0,1... -> out_byte/out_idx held during stalls; full 6-byte sequence 40,rArB,10,00,00,00.
REQ-036 Reset asserted after byte 2 of a 6-byte instruction -> out_valid=0 immediately; a following nop emits only 10 with out_idx=0.
REQ-037 icode=E with ISER_ILLEGAL_CHK_EN defined -> err=1 for one cycle, out_valid stays 0; undefined -> single byte E0 with out_last=1.

Source files
------------

// File: rtl/instr_serializer.sv
// instr_serializer: captures one instruction's fields and emits them as a 1..6 byte stream with ready/valid on both sides.
// Optional macro ISER_ILLEGAL_CHK_EN rejects icode C-F with a one-cycle err pulse instead of emitting them.
module instr_serializer #(
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [31:0] Dest,
    input  logic [31:0] D_V,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [2:0]  out_idx,
    output logic        err
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_nx;
    logic [3:0]  ic_q, fn_q, ra_q, rb_q;
    logic [31:0] dest_q, dv_q;
    logic [2:0]  idx_nx, len;
    logic [3:0]  ra_e, rb_e;
    logic [7:0]  byte_sel;
    logic        accept, legal, take, jump;

`ifdef ISER_ILLEGAL_CHK_EN
    assign legal = icode < 4'hC;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err <= 1'b0;
        else       err <= accept && !legal;
    end
`else
    assign legal = 1'b1;
    assign err   = 1'b0;
`endif

    assign out_valid = state == SEND;
    assign out_last  = out_valid && out_idx == len - 3'd1;
    assign in_ready  = state == IDLE || (out_ready && out_last);
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;
    assign out_byte  = out_valid ? byte_sel : 8'h00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            out_idx <= 3'd0;
            ic_q    <= 4'h0;
            fn_q    <= 4'h0;
            ra_q    <= 4'h0;
            rb_q    <= 4'h0;
            dest_q  <= 32'h0;
            dv_q    <= 32'h0;
        end else begin
            state   <= state_nx;
            out_idx <= idx_nx;
            if (accept) begin
                ic_q   <= icode;
                fn_q   <= ifun;
                ra_q   <= rA;
                rb_q   <= rB;
                dest_q <= Dest;
                dv_q   <= D_V;
            end
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = out_idx;
        if (accept) begin
            state_nx = legal ? SEND : IDLE;
            idx_nx   = 3'd0;
        end else if (take) begin
            state_nx = out_last ? IDLE : SEND;
            idx_nx   = out_last ? 3'd0 : out_idx + 3'd1;
        end
    end

    always_comb begin
        len = 3'd1;
        case (ic_q)
            4'h2, 4'h6, 4'hA, 4'hB: len = 3'd2;
            4'h7, 4'h8:             len = 3'd5;
            4'h3, 4'h4, 4'h5:       len = 3'd6;
            default:                len = 3'd1;
        endcase
    end

    // Jumps/calls put the target straight after byte 0; everything else carries a register byte first.
    assign jump = ic_q == 4'h7 || ic_q == 4'h8;
    assign ra_e = ic_q == 4'h3 ? RNONE : ra_q;
    assign rb_e = (ic_q == 4'hA || ic_q == 4'hB) ? RNONE : rb_q;

    always_comb begin
        byte_sel = 8'h00;
        case (out_idx)
            3'd0:    byte_sel = {ic_q, fn_q};
            3'd1:    byte_sel = jump ? dest_q[7:0]   : {ra_e, rb_e};
            3'd2:    byte_sel = jump ? dest_q[15:8]  : dv_q[7:0];
            3'd3:    byte_sel = jump ? dest_q[23:16] : dv_q[15:8];
            3'd4:    byte_sel = jump ? dest_q[31:24] : dv_q[23:16];
            default: byte_sel = dv_q[31:24];
        endcase
    end
endmodule
